hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_STALL, default 1, bubble cycles per load-use hazard, legal range 1..7.
REQ-003 Parameter PERF_W, default 16, width of the hazard event counter.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 id_ex_memread_i  input  1  EX-stage instruction is a load.
REQ-007 id_ex_rt_i  input  REG_AW  load destination register.
REQ-008 if_id_rs_i  input  REG_AW  ID-stage source register rs.
REQ-009 if_id_rt_i  input  REG_AW  ID-stage source register rt.
REQ-010 if_id_uses_rt_i  input  1  ID-stage instruction reads rt.
REQ-011 branch_taken_i  input  1  branch resolved taken in ID.
REQ-012 mem_stall_i  input  1  data-memory miss; the whole pipeline must freeze.
REQ-013 pc_write_o  output  1  1 = PC may update.
REQ-014 if_id_write_o  output  1  1 = IF/ID register may update.
REQ-015 if_id_flush_o  output  1  1 = IF/ID register loads a NOP.
REQ-016 id_ex_bubble_o  output  1  1 = ID/EX control fields forced to zero.
REQ-017 pipe_hold_o  output  1  1 = all pipeline registers hold.
REQ-018 stall_events_o  output  PERF_W  count of load-use hazards detected.

Function
REQ-019 hazard = id_ex_memread_i & (id_ex_rt_i != 0) & ((id_ex_rt_i == if_id_rs_i) | (if_id_uses_rt_i & (id_ex_rt_i == if_id_rt_i))); register 0 never creates a hazard.
REQ-020 The FSM SHALL have two states: IDLE and LD_STALL, plus a 3-bit down-counter cnt.
REQ-021 Priority, highest first: mem_stall_i, then stall (hazard in IDLE, or state LD_STALL), then branch_taken_i, then normal.
REQ-022 mem_stall_i=1: pipe_hold_o=1, pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, id_ex_bubble_o=0; state, cnt and stall_events_o SHALL be frozen.
REQ-023 Stall in IDLE: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0, all in the same cycle, combinationally.
REQ-024 Stall in IDLE: if LOAD_STALL>1, next state LD_STALL with cnt=LOAD_STALL-1; otherwise remain in IDLE.
REQ-025 LD_STALL: outputs as in REQ-023, hazard input ignored; cnt decrements each unfrozen cycle; at cnt==1 the next state SHALL be IDLE.
REQ-026 branch_taken_i with no stall and no mem_stall: if_id_flush_o=1, pc_write_o=1, if_id_write_o=1, id_ex_bubble_o=0.
REQ-027 Branch coincident with a stall SHALL be suppressed, with no flush; the stalled branch re-presents itself later.
REQ-028 Normal: pc_write_o=1, if_id_write_o=1, all other control outputs 0.
REQ-029 stall_events_o SHALL increment by 1 per hazard detected in IDLE with mem_stall_i=0, once per hazard, not per bubble cycle.
REQ-030 stall_events_o SHALL saturate at all-ones.

Reset
REQ-031 rst_i=0 SHALL immediately force: state IDLE, cnt=0, stall_events_o=0, independent of clk_i.
REQ-032 During reset: pc_write_o=1, if_id_write_o=1, if_id_flush_o=0, id_ex_bubble_o=0, pipe_hold_o=0.
REQ-033 Reset asserted mid-LD_STALL SHALL abort the stall; first cycle after release is IDLE.
REQ-034 Outputs SHALL be valid in the first cycle after rst_i deasserts.

Verification
REQ-035 LOAD_STALL=1, memread=1, id_ex_rt=8, if_id_rs=8 -> one cycle with pc_write=0, if_id_write=0, bubble=1; stall_events=1; next cycle with memread=0 -> normal.
REQ-036 id_ex_rt=0=if_id_rs, memread=1 -> no stall; stall_events unchanged. if_id_rt=8, uses_rt=0, id_ex_rt=8 -> no stall.
REQ-037 LOAD_STALL=3, hazard at cycle 0 -> bubble=1 for cycles 0,1,2; IDLE at cycle 3; stall_events=1.
REQ-038 LOAD_STALL=3, mem_stall_i=1 in cycle 1 for 2 cycles -> hold=1, bubble=0 those cycles; bubbles resume, 3 unfrozen bubble cycles total.
REQ-039 Hazard and branch_taken same cycle -> flush=0, bubble=1; branch alone next cycle -> flush=1, pc_write=1.
REQ-040 PERF_W=2, 5 separate hazards -> stall_events=3; rst_i=0 during LD_STALL -> count 0, state IDLE asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a classic 5-stage in-order pipeline.
//   Detects load-use hazards between the EX-stage load and the ID-stage
//   instruction, inserts LOAD_STALL bubble cycles per hazard, flushes IF/ID
//   on a taken branch and freezes the whole pipe on a data-memory miss.
//   Also counts detected load-use hazards in a saturating event counter.
//
// Parameters
//   REG_AW      register-address width
//   LOAD_STALL  bubble cycles per load-use hazard (1..7)
//   PERF_W      width of the hazard event counter
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   id_ex_memread_i  EX-stage instruction is a load
//   id_ex_rt_i       load destination register
//   if_id_rs_i       ID-stage source register rs
//   if_id_rt_i       ID-stage source register rt
//   if_id_uses_rt_i  ID-stage instruction reads rt
//   branch_taken_i   branch resolved taken in ID
//   mem_stall_i      data-memory miss, freeze the whole pipeline
//   pc_write_o       PC may update
//   if_id_write_o    IF/ID may update
//   if_id_flush_o    IF/ID loads a NOP
//   id_ex_bubble_o   ID/EX control fields forced to zero
//   pipe_hold_o      all pipeline registers hold
//   stall_events_o   number of load-use hazards detected (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int PERF_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_ex_memread_i,
    input  logic [REG_AW-1:0] id_ex_rt_i,
    input  logic [REG_AW-1:0] if_id_rs_i,
    input  logic [REG_AW-1:0] if_id_rt_i,
    input  logic              if_id_uses_rt_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              pipe_hold_o,
    output logic [PERF_W-1:0] stall_events_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        LD_STALL = 1'b1
    } state_e;

    // The first bubble is issued from IDLE, so LD_STALL covers the remaining ones.
    localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] events_q, events_d;
    logic              hazard;
    logic              stall;

    // Register 0 is hard-wired to zero, so a load targeting it never conflicts.
    assign hazard = id_ex_memread_i
                  & (id_ex_rt_i != '0)
                  & ((id_ex_rt_i == if_id_rs_i)
                     | (if_id_uses_rt_i & (id_ex_rt_i == if_id_rt_i)));

    // Once in LD_STALL the hazard input no longer matters: the bubble train
    // runs to completion on the counter alone.
    assign stall = (state_q == LD_STALL) | hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            events_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            events_q <= events_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        events_d       = events_q;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_hold_o    = 1'b0;

        // While reset is held the outputs stay at the free-running values
        // regardless of what the pipeline inputs show.
        if (rst_i) begin
            if (mem_stall_i) begin
                // Memory miss freezes everything, including the stall sequence.
                pipe_hold_o   = 1'b1;
                pc_write_o    = 1'b0;
                if_id_write_o = 1'b0;
            end else if (stall) begin
                // A branch seen here is dropped; it re-presents once the
                // dependent instruction advances.
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
                if (state_q == IDLE) begin
                    if (!(&events_q)) begin
                        events_d = events_q + 1'b1;
                    end
                    if (LOAD_STALL > 1) begin
                        state_d = LD_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end else if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
            end
        end
    end

    assign stall_events_o = events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed testbench for hazard_ctrl. Three instances share one stimulus
//   stream: ls1 (LOAD_STALL=1), ls3 (LOAD_STALL=3) and pw2 (LOAD_STALL=3,
//   PERF_W=2). Each scenario task checks the instance it targets. Control
//   outputs are compared as a packed vector {pc_write, if_id_write,
//   if_id_flush, id_ex_bubble, pipe_hold}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [4:0] C_NORMAL = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_HOLD   = 5'b00001;
    localparam logic [4:0] C_BRANCH = 5'b11100;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       branch;
    logic       mstall;

    logic        a_pc, a_ifid, a_flush, a_bub, a_hold;
    logic        b_pc, b_ifid, b_flush, b_bub, b_hold;
    logic        c_pc, c_ifid, c_flush, c_bub, c_hold;
    logic [15:0] a_ev, b_ev;
    logic [1:0]  c_ev;
    logic [4:0]  a_ctl, b_ctl, c_ctl;

    int checks = 0;
    int errors = 0;

    assign a_ctl = {a_pc, a_ifid, a_flush, a_bub, a_hold};
    assign b_ctl = {b_pc, b_ifid, b_flush, b_bub, b_hold};
    assign c_ctl = {c_pc, c_ifid, c_flush, c_bub, c_hold};

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .PERF_W(16)) u_ls1 (
        .clk_i(clk_i), .rst_i(rst_i), .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt),
        .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
        .branch_taken_i(branch), .mem_stall_i(mstall),
        .pc_write_o(a_pc), .if_id_write_o(a_ifid), .if_id_flush_o(a_flush),
        .id_ex_bubble_o(a_bub), .pipe_hold_o(a_hold), .stall_events_o(a_ev));

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .PERF_W(16)) u_ls3 (
        .clk_i(clk_i), .rst_i(rst_i), .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt),
        .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
        .branch_taken_i(branch), .mem_stall_i(mstall),
        .pc_write_o(b_pc), .if_id_write_o(b_ifid), .if_id_flush_o(b_flush),
        .id_ex_bubble_o(b_bub), .pipe_hold_o(b_hold), .stall_events_o(b_ev));

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .PERF_W(2)) u_pw2 (
        .clk_i(clk_i), .rst_i(rst_i), .id_ex_memread_i(memread), .id_ex_rt_i(ex_rt),
        .if_id_rs_i(id_rs), .if_id_rt_i(id_rt), .if_id_uses_rt_i(uses_rt),
        .branch_taken_i(branch), .mem_stall_i(mstall),
        .pc_write_o(c_pc), .if_id_write_o(c_ifid), .if_id_flush_o(c_flush),
        .id_ex_bubble_o(c_bub), .pipe_hold_o(c_hold), .stall_events_o(c_ev));

    // Inputs are changed 1 time unit after a rising edge; outputs are sampled
    // 1 unit later, well before the next edge.
    task automatic set_in(input logic m, input logic [4:0] ert, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urt, input logic br,
                          input logic ms);
        memread = m; ex_rt = ert; id_rs = rs; id_rt = rt;
        uses_rt = urt; branch = br; mstall = ms;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        // Hazard, branch and miss all present while reset is held.
        set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
        checks++; if (a_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL reset_ctl_ls1 got %b want %b", a_ctl, C_NORMAL); end
        checks++; if (b_ev !== 16'd0) begin errors++; $display("[TB] FAIL reset_ev_ls3 got %0d want 0", b_ev); end
        set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (b_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL reset_ctl_ls3 got %b want %b", b_ctl, C_NORMAL); end
        next_cycle();
        checks++; if (a_ev !== 16'd0) begin errors++; $display("[TB] FAIL reset_ev_held got %0d want 0", a_ev); end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        checks++; if (c_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL reset_release_ctl got %b want %b", c_ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_STALL) begin errors++; $display("[TB] FAIL lu_stall_ctl got %b want %b", a_ctl, C_STALL); end
        next_cycle();
        checks++; if (a_ev !== 16'd1) begin errors++; $display("[TB] FAIL lu_events got %0d want 1", a_ev); end
        set_in(1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL lu_after_ctl got %b want %b", a_ctl, C_NORMAL); end
        next_cycle();
        checks++; if (a_ev !== 16'd1) begin errors++; $display("[TB] FAIL lu_events_hold got %0d want 1", a_ev); end
    endtask

    task automatic test_reg_zero();
        do_reset();
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL r0_ctl got %b want %b", a_ctl, C_NORMAL); end
        next_cycle();
        checks++; if (a_ev !== 16'd0) begin errors++; $display("[TB] FAIL r0_events got %0d want 0", a_ev); end
        set_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL rt_unused_ctl got %b want %b", a_ctl, C_NORMAL); end
        set_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_STALL) begin errors++; $display("[TB] FAIL rt_used_ctl got %b want %b", a_ctl, C_STALL); end
        set_in(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL noload_ctl got %b want %b", a_ctl, C_NORMAL); end
        next_cycle();
    endtask

    task automatic test_multi_cycle();
        do_reset();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (b_ctl !== C_STALL) begin errors++; $display("[TB] FAIL ls3_c0 got %b want %b", b_ctl, C_STALL); end
        next_cycle();
        // Hazard still visible in cycle 1: must not start a second stall or recount.
        checks++; if (b_ctl !== C_STALL) begin errors++; $display("[TB] FAIL ls3_c1 got %b want %b", b_ctl, C_STALL); end
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (b_ctl !== C_STALL) begin errors++; $display("[TB] FAIL ls3_c2 got %b want %b", b_ctl, C_STALL); end
        next_cycle();
        checks++; if (b_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL ls3_c3 got %b want %b", b_ctl, C_NORMAL); end
        checks++; if (b_ev !== 16'd1) begin errors++; $display("[TB] FAIL ls3_events got %0d want 1", b_ev); end
        next_cycle();
    endtask

    task automatic test_mem_stall();
        do_reset();
        // Miss in IDLE with a hazard: hold wins, nothing counted.
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++; if (b_ctl !== C_HOLD) begin errors++; $display("[TB] FAIL ms_idle_ctl got %b want %b", b_ctl, C_HOLD); end
        next_cycle();
        checks++; if (b_ev !== 16'd0) begin errors++; $display("[TB] FAIL ms_idle_events got %0d want 0", b_ev); end
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (b_ctl !== C_STALL) begin errors++; $display("[TB] FAIL ms_c0 got %b want %b", b_ctl, C_STALL); end
        next_cycle();
        for (int i = 1; i <= 2; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            checks++; if (b_ctl !== C_HOLD) begin errors++; $display("[TB] FAIL ms_hold_c%0d got %b want %b", i, b_ctl, C_HOLD); end
            next_cycle();
        end
        for (int i = 3; i <= 4; i++) begin
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            checks++; if (b_ctl !== C_STALL) begin errors++; $display("[TB] FAIL ms_resume_c%0d got %b want %b", i, b_ctl, C_STALL); end
            next_cycle();
        end
        checks++; if (b_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL ms_c5 got %b want %b", b_ctl, C_NORMAL); end
        checks++; if (b_ev !== 16'd1) begin errors++; $display("[TB] FAIL ms_events got %0d want 1", b_ev); end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        checks++; if (a_ctl !== C_STALL) begin errors++; $display("[TB] FAIL br_with_stall got %b want %b", a_ctl, C_STALL); end
        next_cycle();
        set_in(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        checks++; if (a_ctl !== C_BRANCH) begin errors++; $display("[TB] FAIL br_alone got %b want %b", a_ctl, C_BRANCH); end
        set_in(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1);
        checks++; if (a_ctl !== C_HOLD) begin errors++; $display("[TB] FAIL br_with_miss got %b want %b", a_ctl, C_HOLD); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_STALL) begin errors++; $display("[TB] FAIL b2b_first got %b want %b", a_ctl, C_STALL); end
        next_cycle();
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++; if (a_ctl !== C_STALL) begin errors++; $display("[TB] FAIL b2b_second got %b want %b", a_ctl, C_STALL); end
        next_cycle();
        checks++; if (a_ev !== 16'd2) begin errors++; $display("[TB] FAIL b2b_events got %0d want 2", a_ev); end
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        do_reset();
        for (int h = 1; h <= 5; h++) begin
            set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
            next_cycle();
            set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            next_cycle();
            next_cycle();
            next_cycle();
            want = (h >= 3) ? 2'd3 : 2'(h);
            checks++; if (c_ev !== want) begin errors++; $display("[TB] FAIL sat_events_h%0d got %0d want %0d", h, c_ev, want); end
        end
        // Start one more stall, then pull reset in the middle of LD_STALL.
        set_in(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (c_ctl !== C_STALL) begin errors++; $display("[TB] FAIL sat_in_ldstall got %b want %b", c_ctl, C_STALL); end
        #1;
        rst_i = 1'b0;
        #1;
        checks++; if (c_ev !== 2'd0) begin errors++; $display("[TB] FAIL async_rst_events got %0d want 0", c_ev); end
        checks++; if (c_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL async_rst_ctl got %b want %b", c_ctl, C_NORMAL); end
        rst_i = 1'b1;
        #1;
        checks++; if (c_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL post_rst_idle got %b want %b", c_ctl, C_NORMAL); end
        next_cycle();
        checks++; if (c_ctl !== C_NORMAL) begin errors++; $display("[TB] FAIL post_rst_next got %b want %b", c_ctl, C_NORMAL); end
    endtask

    initial begin
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_reg_zero();
        test_multi_cycle();
        test_mem_stall();
        test_branch();
        test_back_to_back();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
